obi_mem_responder: RTL and testbench
====================================

// Module: obi_mem_responder
// PURPOSE
//  Formal-harness OBI memory responder. It sits between the core's imem/dmem request port and
//  the free (rvformal_rand_reg) gnt/rvalid/rdata signals. It turns those unconstrained values
//  into a legal OBI response stream with bounded grant and response latency.
//  One instance is used per port: imem with DATA_WD=32, dmem with DATA_WD=XLEN.
//  TIMEOUT comes from IMEM_TIMEOUT / DMEM_TIMEOUT.
// PARAMETERS
//  TIMEOUT      5   max cycles req_o waits for gnt; max cycles an outstanding txn waits for rvalid (>=1)
//  DATA_WD      32  width of rdata
//  MAX_OUTSTD   2   max granted-but-unanswered transactions (>=1)
// PORTS
//  clk_i          in   1                 clock (rising edge)
//  rst_ni         in   1                 reset, asynchronous, active-low
//  req_i          in   1                 core request (imem_req_o / dmem_req_o)
//  rand_gnt_i     in   1                 free grant proposal
//  rand_rvalid_i  in   1                 free response-valid proposal
//  rand_rdata_i   in   DATA_WD           free read data
//  gnt_o          out  1                 constrained grant to core
//  rvalid_o       out  1                 constrained response valid to core
//  rdata_o        out  DATA_WD           response data to core
//  outstd_o       out  $clog2(MAX_OUTSTD+1)  granted, unanswered transaction count
//  violation_o    out  1                 sticky: core dropped req_i before gnt_o
// BEHAVIOUR
//  State: req_wait (0..TIMEOUT-1, sat), rsp_wait (0..TIMEOUT-1, sat), outstd, viol_q, req_q.
//  Reset (async, rst_ni=0): all state 0. Outputs: gnt_o=0, rvalid_o=0, rdata_o=0, outstd_o=0,
//   violation_o=0. Transactions granted before reset are discarded; they never get rvalid.
//  gnt_o (comb) = req_i & slot_free & (rand_gnt_i | req_wait==TIMEOUT-1)
//   - slot_free = (outstd < MAX_OUTSTD) | rvalid_o
//   - If slots are full, a forced grant waits for the slot; the bound is TIMEOUT plus the response time.
//  rvalid_o (comb) = (outstd != 0) & (rand_rvalid_i | rsp_wait==TIMEOUT-1)
//   - Never in the same cycle as the gnt_o of the txn it answers; earliest is 1 cycle after gnt.
//   - Responses are in grant order.
//  rdata_o = rvalid_o ? rand_rdata_i : '0.
//  outstd next = outstd + gnt_o - rvalid_o.
//   - Simultaneous gnt and rvalid leaves the count unchanged, and is legal at outstd==MAX_OUTSTD.
//  req_wait next:
//   - 0 if !req_i or gnt_o
//   - else min(req_wait+1, TIMEOUT-1)
//  rsp_wait next:
//   - 0 if outstd==0 or rvalid_o
//   - else min(rsp_wait+1, TIMEOUT-1)
//   - After a response, the next txn's bound restarts: at most TIMEOUT cycles after the
//     later of its grant+1 and the previous rvalid.
//  TIMEOUT=1: gnt_o = req_i & slot_free, independent of rand_gnt_i; rvalid_o whenever outstd!=0.
//  violation_o: viol_q is set when req_q & !gnt_q & !req_i.
//   - req_q / gnt_q are registered req_i / gnt_o of the previous cycle.
//   - viol_q stays set until reset. The harness assumes !violation_o.
//  Guarantees to prove:
//   - rvalid_o -> outstd!=0
//   - outstd <= MAX_OUTSTD
//   - req_i held -> gnt_o within TIMEOUT cycles while outstd < MAX_OUTSTD
//   - no X on outputs
// TESTING
//  1 TIMEOUT=5, rand_gnt=0, rand_rvalid=0, req_i=1 from cyc0 -> gnt_o=1 at cyc4 only;
//    outstd=1 at cyc5; rvalid_o=1 at cyc9, rdata_o=rand_rdata_i; outstd=0 at cyc10.
//  2 rand_gnt=1, rand_rvalid=1, req_i=1 held, MAX_OUTSTD=2 -> gnt_o every cycle from cyc0;
//    rvalid_o every cycle from cyc1; outstd stays 1.
//  3 MAX_OUTSTD=2, outstd=2, rand_rvalid=0, rand_gnt=1, req_i=1 -> gnt_o=0 until rvalid_o;
//    in that cycle gnt_o=1 and rvalid_o=1, and outstd stays 2.
//  4 outstd=1, rsp_wait=3, rst_ni pulsed low mid-cycle -> immediate outputs 0;
//    after release, rvalid_o=0 for 10 cycles with req_i=0.
//  5 req_i=1 at cyc0 (rand_gnt=0), req_i=0 at cyc1 -> violation_o=1 from cyc2; it stays 1 until reset.
//  6 TIMEOUT=1, req_i=1, rand_gnt=0, rand_rvalid=0 -> gnt_o=1 at cyc0; rvalid_o=1 at cyc1.

Source files
------------

// File: rtl/obi_mem_responder.sv
// Purpose : turns free gnt/rvalid/rdata proposals into a legal, bounded-latency OBI response stream.
// Latency : gnt_o is combinational on req_i; rvalid_o comes at least 1 cycle after its gnt_o.
// Backpr. : grants stall while all slots are in use and no response retires in that cycle.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   req_i                   core request
//   rand_gnt_i              unconstrained grant proposal
//   rand_rvalid_i           unconstrained response-valid proposal
//   rand_rdata_i            unconstrained read data
//   gnt_o                   constrained grant to the core
//   rvalid_o                constrained response valid to the core
//   rdata_o                 response data, zero when rvalid_o is low
//   outstd_o                count of granted, unanswered transactions
//   violation_o             sticky: the core dropped req_i before it was granted
module obi_mem_responder #(
  parameter int TIMEOUT    = 5,
  parameter int DATA_WD    = 32,
  parameter int MAX_OUTSTD = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_i,
  input  logic                              rand_gnt_i,
  input  logic                              rand_rvalid_i,
  input  logic [DATA_WD-1:0]                rand_rdata_i,
  output logic                              gnt_o,
  output logic                              rvalid_o,
  output logic [DATA_WD-1:0]                rdata_o,
  output logic [$clog2(MAX_OUTSTD+1)-1:0]   outstd_o,
  output logic                              violation_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int OW = $clog2(MAX_OUTSTD + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);
  localparam logic [OW-1:0] OSTD_MAX = OW'(MAX_OUTSTD);

  logic [CW-1:0] r_req_wait;
  logic [CW-1:0] r_rsp_wait;
  logic [OW-1:0] r_outstd;
  logic          r_viol;
  logic          r_req_q;
  logic          r_gnt_q;

  logic [CW-1:0] w_req_wait_nxt;
  logic [CW-1:0] w_rsp_wait_nxt;
  logic [OW-1:0] w_outstd_nxt;
  logic          w_slot_free;
  logic          w_gnt;
  logic          w_rvalid;

  always_comb begin
    // Saturated waits force the grant/response. With TIMEOUT=1 the waits are
    // pinned at 0 == WAIT_MAX, so the random proposals are bypassed entirely.
    // Outputs are gated by reset so nothing is granted or answered while held.
    w_rvalid    = rst_ni && (r_outstd != '0) && (rand_rvalid_i || (r_rsp_wait == WAIT_MAX));
    // A response retiring in this cycle frees its slot for a same-cycle grant.
    w_slot_free = (r_outstd < OSTD_MAX) || w_rvalid;
    w_gnt       = rst_ni && req_i && w_slot_free && (rand_gnt_i || (r_req_wait == WAIT_MAX));

    w_outstd_nxt = r_outstd + OW'(w_gnt) - OW'(w_rvalid);

    w_req_wait_nxt = '0;
    if (req_i && !w_gnt) begin
      w_req_wait_nxt = (r_req_wait == WAIT_MAX) ? WAIT_MAX : r_req_wait + CW'(1);
    end

    // The response bound restarts after every response, so it measures the
    // current head transaction only.
    w_rsp_wait_nxt = '0;
    if ((r_outstd != '0) && !w_rvalid) begin
      w_rsp_wait_nxt = (r_rsp_wait == WAIT_MAX) ? WAIT_MAX : r_rsp_wait + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_wait <= '0;
      r_rsp_wait <= '0;
      r_outstd   <= '0;
      r_viol     <= 1'b0;
      r_req_q    <= 1'b0;
      r_gnt_q    <= 1'b0;
    end else begin
      r_req_wait <= w_req_wait_nxt;
      r_rsp_wait <= w_rsp_wait_nxt;
      r_outstd   <= w_outstd_nxt;
      r_req_q    <= req_i;
      r_gnt_q    <= w_gnt;
      // Request withdrawn while still ungranted: latch until reset.
      if (r_req_q && !r_gnt_q && !req_i) begin
        r_viol <= 1'b1;
      end
    end
  end

  assign gnt_o       = w_gnt;
  assign rvalid_o    = w_rvalid;
  assign rdata_o     = w_rvalid ? rand_rdata_i : '0;
  assign outstd_o    = r_outstd;
  assign violation_o = r_viol;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: two instances (TIMEOUT=5/MAX_OUTSTD=2/32b and
// TIMEOUT=1/MAX_OUTSTD=1/8b) share one stimulus stream. A timestamp-based
// reference model predicts each cycle's outputs into a queue; a negedge
// monitor pops and compares.
module tb_obi_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, rg, rvp;
  logic [31:0] rd;
  logic [7:0]  rd8;
  assign rd8 = rd[7:0];

  logic        gnt0, rv0, viol0;
  logic [31:0] rdo0;
  logic [1:0]  os0;
  logic        gnt1, rv1, viol1;
  logic [7:0]  rdo1;
  logic [0:0]  os1;

  obi_mem_responder #(.TIMEOUT(5), .DATA_WD(32), .MAX_OUTSTD(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .rand_gnt_i(rg), .rand_rvalid_i(rvp),
    .rand_rdata_i(rd), .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rdo0), .outstd_o(os0),
    .violation_o(viol0));

  obi_mem_responder #(.TIMEOUT(1), .DATA_WD(8), .MAX_OUTSTD(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .rand_gnt_i(rg), .rand_rvalid_i(rvp),
    .rand_rdata_i(rd8), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rdo1), .outstd_o(os1),
    .violation_o(viol1));

  typedef struct packed {
    logic        gnt;
    logic        rv;
    logic        viol;
    logic [1:0]  os;
    logic [31:0] rd;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } pair_t;

  pair_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: per instance, grant timestamps of outstanding txns, the
  // cycle of the last response and the last cycle a request was "broken"
  // (absent or granted). Deadlines follow from elapsed time since those events.
  int tmo[2]  = '{5, 1};
  int mx[2]   = '{2, 1};
  int qn[2];
  int gc[2][4];
  int last_rv[2];
  int last_brk[2];
  bit viol_m[2];
  bit preq[2];
  bit pgnt[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      qn[m] = 0; last_rv[m] = -100; last_brk[m] = cyc;
      viol_m[m] = 1'b0; preq[m] = 1'b0; pgnt[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input bit r, input bit g, input bit v,
                            input logic [31:0] d, output exp_t e);
    int  t;
    int  elig;
    bit  req_due, rvx, gx, sf;
    t       = tmo[m];
    req_due = (cyc - (last_brk[m] + 1)) >= (t - 1);
    rvx     = 1'b0;
    if (qn[m] > 0) begin
      elig = (gc[m][0] + 1 > last_rv[m] + 1) ? gc[m][0] + 1 : last_rv[m] + 1;
      rvx  = v || ((cyc - elig) >= (t - 1));
    end
    sf = (qn[m] < mx[m]) || rvx;
    gx = r && sf && (g || req_due);
    e.gnt  = gx;
    e.rv   = rvx;
    e.viol = viol_m[m];
    e.os   = 2'(qn[m]);
    e.rd   = rvx ? ((m == 0) ? d : {24'b0, d[7:0]}) : 32'b0;
    if (rvx) begin
      for (int i = 0; i < 3; i++) gc[m][i] = gc[m][i+1];
      qn[m]--;
      last_rv[m] = cyc;
    end
    if (gx) begin
      gc[m][qn[m]] = cyc;
      qn[m]++;
    end
    if (!r || gx) last_brk[m] = cyc;
    if (preq[m] && !pgnt[m] && !r) viol_m[m] = 1'b1;
    preq[m] = r;
    pgnt[m] = gx;
  endtask

  task automatic drive(input bit r, input bit g, input bit v, input logic [31:0] d);
    pair_t p;
    exp_t  ea, eb;
    @(posedge clk);
    #1;
    req = r; rg = g; rvp = v; rd = d;
    cyc++;
    model_step(0, r, g, v, d, ea);
    model_step(1, r, g, v, d, eb);
    p.a = ea;
    p.b = eb;
    exp_q.push_back(p);
  endtask

  // Reset asserted mid-cycle with every proposal high: outputs must drop at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    req = 1'b1; rg = 1'b1; rvp = 1'b1; rd = $urandom;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);  chk("rst_rv0", rv0, 0);   chk("rst_rd0", rdo0, 0);
    chk("rst_os0", os0, 0);    chk("rst_viol0", viol0, 0);
    chk("rst_gnt1", gnt1, 0);  chk("rst_rv1", rv1, 0);   chk("rst_rd1", rdo1, 0);
    chk("rst_os1", os1, 0);    chk("rst_viol1", viol1, 0);
    repeat (3) @(negedge clk);
    req = 1'b0; rg = 1'b0; rvp = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    pair_t p;
    if (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      chk("gnt0", gnt0, p.a.gnt);   chk("rvalid0", rv0, p.a.rv);
      chk("rdata0", rdo0, p.a.rd);  chk("outstd0", os0, p.a.os);
      chk("viol0", viol0, p.a.viol);
      chk("gnt1", gnt1, p.b.gnt);   chk("rvalid1", rv1, p.b.rv);
      chk("rdata1", rdo1, p.b.rd);  chk("outstd1", os1, p.b.os);
      chk("viol1", viol1, p.b.viol);
    end
  end

  initial begin
    bit r;
    rst_n = 1'b1; req = 1'b0; rg = 1'b0; rvp = 1'b0; rd = '0;

    // Forced grant after TIMEOUT-1 waits, forced response later.
    do_reset();
    repeat (5) drive(1'b1, 1'b0, 1'b0, $urandom);
    repeat (7) drive(1'b0, 1'b0, 1'b0, $urandom);

    // Back-to-back grant and response every cycle.
    do_reset();
    repeat (8) drive(1'b1, 1'b1, 1'b1, $urandom);

    // Slots full: grant only together with the forced response.
    do_reset();
    repeat (12) drive(1'b1, 1'b1, 1'b0, $urandom);

    // Reset while a transaction is outstanding discards it.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, $urandom);
    repeat (3) drive(1'b0, 1'b0, 1'b0, $urandom);
    do_reset();
    repeat (10) drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, $urandom);

    // Randomized legal traffic: request held until granted.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (preq[0] && !pgnt[0]) r = 1'b1;
      else r = ($urandom_range(0, 2) != 0);
      drive(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom);
    end

    // Request withdrawn before grant: sticky violation, cleared by reset.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, $urandom);
    repeat (6) drive(1'b0, 1'b0, 1'b0, $urandom);
    do_reset();
    repeat (2) drive(1'b0, 1'b0, 1'b0, $urandom);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
